// File: rtl/block_move_pkg.sv
// Shared types and constants for the block move/swap unit.
package block_move_pkg;

    localparam int unsigned BMU_DATA_W   = 32;
    localparam int unsigned BMU_ADDR_W   = 8;
    localparam int unsigned BMU_LEN_W    = 8;
    localparam int unsigned BMU_FLAG_W   = 8;
    localparam int unsigned BMU_SEL_W    = $clog2(BMU_FLAG_W);
    localparam int unsigned BMU_CYC_COPY = 2;
    localparam int unsigned BMU_CYC_SWAP = 4;

    typedef enum logic {
        BMU_COPY = 1'b0,
        BMU_SWAP = 1'b1
    } bmu_mode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PTR_S_RD,
        S_PTR_S_CAP,
        S_PTR_D_RD,
        S_PTR_D_CAP,
        S_RD,
        S_WR,
        S_RD_A,
        S_RD_B,
        S_WR_A,
        S_WR_B,
        S_DONE
    } bmu_state_e;

    typedef struct packed {
        bmu_mode_e              mode;
        logic [BMU_ADDR_W-1:0]  src;
        logic [BMU_ADDR_W-1:0]  dst;
        logic                   src_ptr;
        logic                   dst_ptr;
        logic [BMU_LEN_W-1:0]   len;
        logic                   cond_en;
        logic [BMU_SEL_W-1:0]   cond_sel;
        logic                   cond_val;
    } bmu_cmd_t;

    // First per-word state once both bases are known.
    function automatic bmu_state_e bmu_word_start(input bmu_mode_e mode);
        return (mode == BMU_SWAP) ? S_RD_A : S_RD;
    endfunction

endpackage

// File: rtl/block_move_unit_if.sv
// Command handshake plus register-file port bundle of the block move unit.
interface block_move_unit_if
    import block_move_pkg::*;
#(
    parameter int unsigned DATA_W = BMU_DATA_W,
    parameter int unsigned ADDR_W = BMU_ADDR_W,
    parameter int unsigned LEN_W  = BMU_LEN_W,
    parameter int unsigned FLAG_W = BMU_FLAG_W
);
    localparam int unsigned SEL_W = $clog2(FLAG_W);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic              cmd_src_ptr;
    logic              cmd_dst_ptr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_cond_en;
    logic [SEL_W-1:0]  cmd_cond_sel;
    logic              cmd_cond_val;
    logic [FLAG_W-1:0] flags;
    logic              rf_re;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy;
    logic              done;
    logic              done_skipped;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_src_ptr, cmd_dst_ptr, cmd_len,
               cmd_cond_en, cmd_cond_sel, cmd_cond_val, flags, rf_rdata,
        output cmd_ready, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata, busy, done, done_skipped
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_src_ptr, cmd_dst_ptr, cmd_len,
               cmd_cond_en, cmd_cond_sel, cmd_cond_val, flags, rf_rdata,
        input  cmd_ready, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata, busy, done, done_skipped
    );

endinterface

// File: rtl/bmu_addr_gen.sv
// Base/counter address generator; BMU_REVERSE_COPY_EN enables descending COPY for dst-above-src overlap.
module bmu_addr_gen
    import block_move_pkg::*;
#(
    parameter int unsigned ADDR_W = BMU_ADDR_W,
    parameter int unsigned LEN_W  = BMU_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              ld_src_ptr,
    input  logic              ld_dst_ptr,
    input  logic              step,
    input  bmu_mode_e         mode,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [ADDR_W-1:0] ptr_word,
    output logic [ADDR_W-1:0] src_base,
    output logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last_word
);
`ifdef BMU_REVERSE_COPY_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif
    localparam int unsigned CMP_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  offset;
    logic [ADDR_W-1:0] diff;
    logic              rev;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_base <= '0;
            dst_base <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (load) begin
                src_base <= src_in;
                dst_base <= dst_in;
                len_q    <= len_in;
                cnt_q    <= '0;
            end
            if (ld_src_ptr) src_base <= ptr_word;
            if (ld_dst_ptr) dst_base <= ptr_word;
            if (step)       cnt_q    <= cnt_q + LEN_W'(1);
        end
    end

    // Bases are stable during the word phase, so direction follows resolved pointers.
    assign diff   = dst_base - src_base;
    assign rev    = REV_EN && (mode == BMU_COPY) && (diff != '0)
                    && (CMP_W'(diff) < CMP_W'(len_q));
    assign offset = rev ? (len_q - LEN_W'(1) - cnt_q) : cnt_q;

    assign src_addr  = src_base + ADDR_W'(offset);
    assign dst_addr  = dst_base + ADDR_W'(offset);
    assign last_word = (cnt_q == (len_q - LEN_W'(1)));

endmodule

// File: rtl/block_move_unit.sv
// Sequential block COPY/SWAP over the exe-env register file, one access per cycle.
// Optional BMU_REVERSE_COPY_EN (see bmu_addr_gen) gives memmove-style COPY.
module block_move_unit
    import block_move_pkg::*;
#(
    parameter int unsigned DATA_W = BMU_DATA_W,
    parameter int unsigned ADDR_W = BMU_ADDR_W,
    parameter int unsigned LEN_W  = BMU_LEN_W,
    parameter int unsigned FLAG_W = BMU_FLAG_W
) (
    input  logic             clk,
    input  logic             rst,
    block_move_unit_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(FLAG_W);

    bmu_state_e        state_q;
    bmu_state_e        state_d;
    bmu_cmd_t          cmd_in;
    bmu_mode_e         mode_q;
    logic              dst_ptr_q;
    logic              skip_q;
    logic [DATA_W-1:0] a_q;
    logic [SEL_W-1:0]  cond_sel;
    logic              accept;
    logic              cond_fail;
    logic              ld_src_ptr;
    logic              ld_dst_ptr;
    logic              step;
    logic              cap_a;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              last_word;

    always_comb begin
        cmd_in.mode     = bmu_mode_e'(bus.cmd_mode);
        cmd_in.src      = BMU_ADDR_W'(bus.cmd_src);
        cmd_in.dst      = BMU_ADDR_W'(bus.cmd_dst);
        cmd_in.src_ptr  = bus.cmd_src_ptr;
        cmd_in.dst_ptr  = bus.cmd_dst_ptr;
        cmd_in.len      = BMU_LEN_W'(bus.cmd_len);
        cmd_in.cond_en  = bus.cmd_cond_en;
        cmd_in.cond_sel = BMU_SEL_W'(bus.cmd_cond_sel);
        cmd_in.cond_val = bus.cmd_cond_val;
    end

    assign cond_sel  = SEL_W'(cmd_in.cond_sel);
    assign cond_fail = cmd_in.cond_en && (bus.flags[cond_sel] != cmd_in.cond_val);
    assign accept    = bus.cmd_valid && (state_q == S_IDLE);

    bmu_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .ld_src_ptr (ld_src_ptr),
        .ld_dst_ptr (ld_dst_ptr),
        .step       (step),
        .mode       (mode_q),
        .src_in     (ADDR_W'(cmd_in.src)),
        .dst_in     (ADDR_W'(cmd_in.dst)),
        .len_in     (LEN_W'(cmd_in.len)),
        .ptr_word   (bus.rf_rdata[ADDR_W-1:0]),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .last_word  (last_word)
    );

    // Command attributes and the swap holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= BMU_COPY;
            dst_ptr_q <= 1'b0;
            skip_q    <= 1'b0;
            a_q       <= '0;
        end else begin
            if (accept) begin
                mode_q    <= cmd_in.mode;
                dst_ptr_q <= cmd_in.dst_ptr;
                skip_q    <= cond_fail;
            end
            if (cap_a) a_q <= bus.rf_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cond_fail || (cmd_in.len == '0)) state_d = S_DONE;
                    else if (cmd_in.src_ptr)             state_d = S_PTR_S_RD;
                    else if (cmd_in.dst_ptr)             state_d = S_PTR_D_RD;
                    else                                 state_d = bmu_word_start(cmd_in.mode);
                end
            end
            S_PTR_S_RD:  state_d = S_PTR_S_CAP;
            S_PTR_S_CAP: state_d = dst_ptr_q ? S_PTR_D_RD : bmu_word_start(mode_q);
            S_PTR_D_RD:  state_d = S_PTR_D_CAP;
            S_PTR_D_CAP: state_d = bmu_word_start(mode_q);
            S_RD:        state_d = S_WR;
            S_WR:        state_d = last_word ? S_DONE : S_RD;
            S_RD_A:      state_d = S_RD_B;
            S_RD_B:      state_d = S_WR_A;
            S_WR_A:      state_d = S_WR_B;
            S_WR_B:      state_d = last_word ? S_DONE : S_RD_A;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready    = 1'b0;
        bus.busy         = 1'b1;
        bus.done         = 1'b0;
        bus.done_skipped = 1'b0;
        bus.rf_re        = 1'b0;
        bus.rf_raddr     = '0;
        bus.rf_we        = 1'b0;
        bus.rf_waddr     = '0;
        bus.rf_wdata     = '0;
        ld_src_ptr       = 1'b0;
        ld_dst_ptr       = 1'b0;
        step             = 1'b0;
        cap_a            = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            S_PTR_S_RD:  begin bus.rf_re = 1'b1; bus.rf_raddr = src_base; end
            S_PTR_S_CAP: ld_src_ptr = 1'b1;
            S_PTR_D_RD:  begin bus.rf_re = 1'b1; bus.rf_raddr = dst_base; end
            S_PTR_D_CAP: ld_dst_ptr = 1'b1;
            S_RD:        begin bus.rf_re = 1'b1; bus.rf_raddr = src_addr; end
            S_WR: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = dst_addr;
                bus.rf_wdata = bus.rf_rdata;
                step         = !last_word;
            end
            S_RD_A:      begin bus.rf_re = 1'b1; bus.rf_raddr = src_addr; end
            S_RD_B: begin
                bus.rf_re    = 1'b1;
                bus.rf_raddr = dst_addr;
                cap_a        = 1'b1;
            end
            S_WR_A: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = src_addr;
                bus.rf_wdata = bus.rf_rdata;
            end
            S_WR_B: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = dst_addr;
                bus.rf_wdata = a_q;
                step         = !last_word;
            end
            S_DONE: begin
                bus.done         = 1'b1;
                bus.done_skipped = skip_q;
            end
            default: ;
        endcase
        // Reset aborts immediately: no access may land on the reset edge.
        if (rst) begin
            bus.rf_re = 1'b0;
            bus.rf_we = 1'b0;
        end
    end

endmodule
